// File: rtl/collatz_pkg.sv
// Shared types and status codes for the Collatz sequence engine.
// Optional fast odd-step mode is selected in the top by COLLATZ_FAST_EN.
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ZERO  = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_LIMIT = 2'b11;

endpackage

// File: rtl/collatz_step.sv
// Combinational single Collatz map step, with optional merged (3n+1)/2 on odd values.
module collatz_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             fast_en,
  output logic [WIDTH-1:0] nxt,
  output logic [1:0]       inc,
  output logic             ovf,
  output logic [WIDTH-1:0] peak_cand
);

  logic [WIDTH+1:0] t;

  always_comb begin
    t         = ({2'b00, cur} << 1) + {2'b00, cur} + (WIDTH+2)'(1);
    nxt       = cur >> 1;
    inc       = 2'd1;
    ovf       = 1'b0;
    peak_cand = cur >> 1;
    if (cur[0]) begin
      ovf       = |t[WIDTH+1:WIDTH];
      // the unshifted 3n+1 always dominates its half, so it is the peak candidate
      peak_cand = t[WIDTH-1:0];
      if (fast_en) begin
        nxt = t[WIDTH:1];
        inc = 2'd2;
      end else begin
        nxt = t[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/collatz_seq_engine.sv
// Collatz sequence engine: accepts a seed, iterates to 1, reports steps/peak/status.
// Define COLLATZ_FAST_EN to merge each odd step with the following halving.
module collatz_seq_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 10,
  parameter int STEP_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] peak,
  output logic [1:0]       status,
  output logic             busy
);

`ifdef COLLATZ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(STEP_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STEP_LIMIT - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] peak_cand;
  logic [1:0]       inc;
  logic             ovf;
  logic             fast_en;
  logic             at_one;
  logic             at_zero;
  logic             at_limit;

  // a double step right before the limit would overshoot it
  assign fast_en  = FAST && (steps != LIMIT_M1);
  assign at_one   = (cur == WIDTH'(1));
  assign at_zero  = (cur == '0);
  assign at_limit = (steps == LIMIT);

  collatz_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .cur       (cur),
    .fast_en   (fast_en),
    .nxt       (nxt),
    .inc       (inc),
    .ovf       (ovf),
    .peak_cand (peak_cand)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // a zero seed passes through RUN for one cycle so its result appears one edge after accept
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (at_zero || at_one || at_limit || ovf) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur    <= '0;
      steps  <= '0;
      peak   <= '0;
      status <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur    <= seed;
            peak   <= seed;
            steps  <= '0;
            status <= ST_OK;
          end
        end
        RUN: begin
          if (at_zero) begin
            status <= ST_ZERO;
          end else if (at_one) begin
            status <= ST_OK;
          end else if (at_limit) begin
            status <= ST_LIMIT;
          end else if (ovf) begin
            status <= ST_OVF;
          end else begin
            cur   <= nxt;
            steps <= steps + CNT_W'(inc);
            if (peak_cand > peak) peak <= peak_cand;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/collatz_seq_engine.md
Name: collatz_seq_engine

Overview:
- Parametrised successor to the single-step Collatz datapath.
- Accepts a seed over a valid/ready handshake and iterates the Collatz map internally, one step per clock, until the value reaches 1.
- Returns step count, peak value and a status code over a second valid/ready handshake.
- Detects zero seeds, arithmetic overflow and runaway sequences, so it runs standalone behind the chip I/O wrapper.

Parameters:
- WIDTH, 16, data width of seed, running value and peak.
- CNT_W, 10, width of the step counter.
- STEP_LIMIT, 1000, maximum steps before abort. Must be < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  seed offered
- in_ready  out  1  engine can accept a seed
- seed  in  WIDTH  starting value
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- steps  out  CNT_W  number of map applications performed
- peak  out  WIDTH  maximum value reached, including the seed
- status  out  2  00 OK, 01 ZERO_SEED, 10 OVERFLOW, 11 STEP_LIMIT
- busy  out  1  high in RUN state

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - State IDLE.
  - in_ready=1; out_valid=0; busy=0.
  - steps=0; peak=0; status=00.
  - Internal current value=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: cur<=seed, peak<=seed, steps<=0.
  - Seed 0: go to DONE with status=01.
  - Otherwise: go to RUN.
- RUN: one decision per clock, with busy=1 and in_ready=0.
  - cur==1: go to DONE, status=00.
  - Else steps==STEP_LIMIT: go to DONE, status=11.
  - Else cur even: cur<=cur>>1; steps+1.
  - Else cur odd: t=3*cur+1, computed in WIDTH+2 bits.
    - If t>=2**WIDTH: go to DONE, status=10. cur, steps and peak keep their pre-step values.
    - Else cur<=t; steps+1.
  - peak<=max(peak, new cur) on every committed step.
- Latency: a sequence of k steps gives out_valid high from edge E(k+1).
  - Seed 1: out_valid at E1, steps=0.
  - Seed 0: out_valid at E1.
- DONE:
  - out_valid=1; steps, peak and status held stable.
  - in_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid<=0.
- Backpressure: results hold indefinitely. A new seed is accepted only in IDLE, so there is no simultaneous accept and return.
- Edge cases:
  - in_valid while busy is ignored; no buffering.
  - Reset asserted mid-RUN or mid-DONE returns to reset values immediately; no result is emitted.
- Width rules:
  - steps never exceeds STEP_LIMIT.
  - peak never wraps, because the overflow check precedes the commit.

Optional Feature:
- Macro COLLATZ_FAST_EN.
- When defined, an odd step commits (3*cur+1)>>1 in one cycle and adds 2 to steps.
  - The overflow check still applies to the unshifted 3*cur+1.
  - peak is updated with the unshifted 3*cur+1, then with the halved value.
  - If steps==STEP_LIMIT-1, the odd step falls back to the single 3n+1 step.
- With the macro: reported steps, peak and status are identical to the non-fast build; only latency shrinks.
- Without the macro: one map application per cycle, as described above.

Decomposition:
- Package collatz_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - status localparams ST_OK, ST_ZERO, ST_OVF, ST_LIMIT.
- One natural sub-module: collatz_step.
  - Combinational.
  - Inputs: cur and fast-enable.
  - Outputs: next value, step increment, overflow flag, intermediate peak candidate.
- The FSM, counters and handshake live in the top.

Test Plan:
- WIDTH=16: seed 27 -> status 00, steps 111, peak 9232; out_valid at E112 (non-fast build).
- Seed 1 -> out_valid one cycle after accept, steps 0, peak 1, status 00. Seed 0 -> status 01, steps 0, peak 0.
- WIDTH=8, seed 27 -> overflow at 3*107+1=322 -> status 10, steps 11, peak 214.
- STEP_LIMIT=100, seed 27 -> status 11, steps 100, peak 9232.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - in_valid pulses during RUN are ignored.
  - After the handshake, in_ready=1 next cycle.
- Reset and fast build:
  - Assert rst_n=0 mid-RUN (seed 27, step 40) -> all outputs at reset values, no out_valid.
  - The fast build repeats the seed 27 case -> identical steps/peak/status with fewer cycles.
